// File: rtl/proc_pkg.sv
// Shared types and constants for the command fetch unit.
// Holds the fetch-state encoding, command geometry and field positions.
// No logic here; imported by the fetch FSM and the byte assembly register.
package proc_pkg;

    localparam int COMMAND_BYTES = 3;
    localparam int BYTE_W        = 8;
    localparam int CMD_W         = COMMAND_BYTES * BYTE_W;
    localparam int ADDR_W        = 16;

    localparam logic [7:0] HALT_OPCODE_DEFAULT = 8'hFF;

    // Command layout: opcode in the top byte, 16-bit address field below.
    localparam int OPCODE_MSB     = 23;
    localparam int OPCODE_LSB     = 16;
    localparam int ADDR_FIELD_MSB = 15;
    localparam int ADDR_FIELD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_CAP,
        ST_VALID,
        ST_HALT
    } fetch_state_e;

    // Which byte of the command a returning memory byte lands in.
    typedef enum logic [1:0] {
        BYTE_OPCODE  = 2'd0,
        BYTE_ADDR_HI = 2'd1,
        BYTE_ADDR_LO = 2'd2
    } byte_sel_e;

    function automatic logic [7:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
        return cmd[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/command_shift_reg.sv
// Command assembly register: drops one memory byte into a selected lane.
// Latency: byte visible on q_o the clock after ld_i; clear wins over load.
// No backpressure; the fetch FSM decides when each lane is written.
module command_shift_reg
    import proc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              ld_i,
    input  byte_sel_e         sel_i,
    input  logic [BYTE_W-1:0] din_i,
    output logic [CMD_W-1:0]  q_o
);

    logic [CMD_W-1:0] q_q;
    logic [CMD_W-1:0] q_d;

    // Lane select: clear discards a partial command, load writes one byte.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            case (sel_i)
                BYTE_OPCODE:  q_d[OPCODE_MSB:OPCODE_LSB]        = din_i;
                BYTE_ADDR_HI: q_d[ADDR_FIELD_MSB -: BYTE_W]     = din_i;
                default:      q_d[ADDR_FIELD_LSB +: BYTE_W]     = din_i;
            endcase
        end
    end

    // Assembly register with asynchronous clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/command_fetch.sv
// Fetches 3-byte commands from byte-wide program memory and presents them to decode.
// Latency: commandValid 4 clocks after F0; memory data expected 1 clock after memRead.
// Backpressure: commandReady=0 parks the block in VALID with no memory reads issued.
module command_fetch
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDRESS = 16'h0000,
    parameter logic [7:0]        HALT_OPCODE   = HALT_OPCODE_DEFAULT
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddress,
    output logic              memRead,
    output logic [ADDR_W-1:0] memAddress,
    input  logic [BYTE_W-1:0] memData,
    output logic [CMD_W-1:0]  commandOut,
    output logic              commandValid,
    input  logic              commandReady,
    output logic [ADDR_W-1:0] commandAddress,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic      sr_clr;
    logic      sr_ld;
    byte_sel_e sr_sel;

    // State and program counter; reset drops any in-flight command.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDRESS;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, memory request and byte capture. A redirect in any fetch
    // state or in VALID restarts at the target and clears partial bytes, so
    // a command never mixes bytes from before and after the jump.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        memRead      = 1'b0;
        memAddress   = pc_q;
        commandValid = 1'b0;
        halted       = 1'b0;
        sr_clr       = 1'b0;
        sr_ld        = 1'b0;
        sr_sel       = BYTE_OPCODE;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_F0;
            end
            ST_F0, ST_F1, ST_F2, ST_CAP: begin
                if (state_q != ST_CAP) memRead = 1'b1;
                if (state_q == ST_F1) memAddress = pc_q + 16'd1;
                if (state_q == ST_F2) memAddress = pc_q + 16'd2;
                if (redirect) begin
                    pc_d    = redirectAddress;
                    state_d = ST_F0;
                    sr_clr  = 1'b1;
                end else begin
                    case (state_q)
                        ST_F0:   state_d = ST_F1;
                        ST_F1:   begin state_d = ST_F2;    sr_ld = 1'b1; sr_sel = BYTE_OPCODE;  end
                        ST_F2:   begin state_d = ST_CAP;   sr_ld = 1'b1; sr_sel = BYTE_ADDR_HI; end
                        default: begin state_d = ST_VALID; sr_ld = 1'b1; sr_sel = BYTE_ADDR_LO; end
                    endcase
                end
            end
            ST_VALID: begin
                commandValid = 1'b1;
                if (redirect) begin
                    pc_d    = redirectAddress;
                    state_d = ST_F0;
                    sr_clr  = 1'b1;
                end else if (commandReady) begin
                    if (cmd_opcode(commandOut) == HALT_OPCODE) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + 16'(COMMAND_BYTES);
                        state_d = ST_F0;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign commandAddress = pc_q;

    command_shift_reg u_shift_reg (
        .clk_i  (clock),
        .rst_ni (resetN),
        .clr_i  (sr_clr),
        .ld_i   (sr_ld),
        .sel_i  (sr_sel),
        .din_i  (memData),
        .q_o    (commandOut)
    );

endmodule

// File: tb/tb_command_fetch.sv
// Directed bench for command_fetch: table of command fetches plus hand sequences.
// Memory model returns mem[memAddress] one clock after the request.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_command_fetch;

    logic        clock;
    logic        resetN;
    logic        start;
    logic        redirect;
    logic [15:0] redirectAddress;
    logic        memRead;
    logic [15:0] memAddress;
    logic [7:0]  memData;
    logic [23:0] commandOut;
    logic        commandValid;
    logic        commandReady;
    logic [15:0] commandAddress;
    logic        halted;

    logic [7:0] mem [0:65535];
    logic       saw39;

    int checks = 0;
    int errors = 0;

    command_fetch #(
        .RESET_ADDRESS (16'h0000),
        .HALT_OPCODE   (8'hFF)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .start           (start),
        .redirect        (redirect),
        .redirectAddress (redirectAddress),
        .memRead         (memRead),
        .memAddress      (memAddress),
        .memData         (memData),
        .commandOut      (commandOut),
        .commandValid    (commandValid),
        .commandReady    (commandReady),
        .commandAddress  (commandAddress),
        .halted          (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        memData <= mem[memAddress];
        if (memRead && memAddress == 16'd39) saw39 <= 1'b1;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          stall;
        logic        redir;
        logic [15:0] raddr;
        logic [23:0] cmd;
        logic [15:0] nxt;
    } vec_t;

    vec_t        vecs [7];
    vec_t        v;
    logic [15:0] a1, a2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ctl"}, {29'd0, memRead, commandValid, halted}, 32'd0);
        chk({name, "_maddr"}, {16'd0, memAddress}, 32'h0000);
        chk({name, "_cmd"}, {8'd0, commandOut}, 32'h0);
        chk({name, "_caddr"}, {16'd0, commandAddress}, 32'h0000);
    endtask

    initial begin
        // addr, bytes, stall, redirect, target, expected command, expected next pc
        vecs[0] = '{16'h0000, 8'h11, 8'h02, 8'h04, 0, 1'b0, 16'h0000, 24'h110204, 16'h0003};
        vecs[1] = '{16'h0003, 8'h21, 8'h02, 8'h14, 5, 1'b0, 16'h0000, 24'h210214, 16'h0006};
        vecs[2] = '{16'h0006, 8'hAA, 8'hBB, 8'hCC, 0, 1'b1, 16'h0024, 24'hAABBCC, 16'h0024};
        vecs[3] = '{16'h0024, 8'hFE, 8'h00, 8'h18, 0, 1'b1, 16'h0018, 24'hFE0018, 16'h0018};
        vecs[4] = '{16'h0018, 8'h12, 8'h34, 8'h56, 0, 1'b0, 16'h0000, 24'h123456, 16'h001B};
        vecs[5] = '{16'h001B, 8'hFF, 8'h00, 8'h01, 0, 1'b1, 16'hFFFE, 24'hFF0001, 16'hFFFE};
        vecs[6] = '{16'hFFFE, 8'h7E, 8'h7F, 8'h11, 0, 1'b0, 16'h0000, 24'h7E7F11, 16'h0001};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 7; i++) begin
            a1 = vecs[i].addr + 16'd1;
            a2 = vecs[i].addr + 16'd2;
            mem[vecs[i].addr] = vecs[i].b0;
            mem[a1]           = vecs[i].b1;
            mem[a2]           = vecs[i].b2;
        end
        mem[16'h0100] = 8'h5A; mem[16'h0101] = 8'h6B; mem[16'h0102] = 8'h7C;
        mem[16'h0103] = 8'hFF; mem[16'h0104] = 8'hFF; mem[16'h0105] = 8'hFF;

        saw39           = 1'b0;
        start           = 1'b0;
        redirect        = 1'b0;
        redirectAddress = 16'h0000;
        commandReady    = 1'b0;
        resetN          = 1'b1;
        #1 resetN = 1'b0;
        #1 chk_reset_outputs("reset0");

        tick();
        resetN = 1'b1;
        tick();
        chk("idle_no_read", {31'd0, memRead}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_f0", {15'd0, memRead, memAddress}, {15'd0, 1'b1, 16'h0000});

        // Table-driven fetches: F0 is current on entry to each iteration.
        for (int i = 0; i < 7; i++) begin
            v  = vecs[i];
            a1 = v.addr + 16'd1;
            a2 = v.addr + 16'd2;
            tick();
            chk("f1_addr", {15'd0, memRead, memAddress}, {15'd0, 1'b1, a1});
            tick();
            chk("f2_addr", {15'd0, memRead, memAddress}, {15'd0, 1'b1, a2});
            tick();
            chk("cap_idle", {30'd0, memRead, commandValid}, 32'd0);
            tick();
            chk("valid", {31'd0, commandValid}, 32'd1);
            chk("cmd", {8'd0, commandOut}, {8'd0, v.cmd});
            chk("cmd_addr", {16'd0, commandAddress}, {16'd0, v.addr});
            for (int s = 0; s < v.stall; s++) begin
                tick();
                chk("stall_ctl", {30'd0, commandValid, memRead}, 32'd2);
                chk("stall_cmd", {8'd0, commandOut}, {8'd0, v.cmd});
            end
            commandReady    = 1'b1;
            redirect        = v.redir;
            redirectAddress = v.raddr;
            tick();
            commandReady = 1'b0;
            redirect     = 1'b0;
            chk("next_f0", {14'd0, memRead, halted, memAddress}, {14'd0, 1'b1, 1'b0, v.nxt});
        end

        // Mid-fetch flush: now in F0 at 0001; redirect while in F2.
        tick();
        tick();
        chk("flush_f2", {15'd0, memRead, memAddress}, {15'd0, 1'b1, 16'h0003});
        redirect        = 1'b1;
        redirectAddress = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("flush_f0", {14'd0, memRead, commandValid, memAddress}, {14'd0, 1'b1, 1'b0, 16'h0100});
        tick();
        chk("flush_f1", {14'd0, memRead, commandValid, memAddress}, {14'd0, 1'b1, 1'b0, 16'h0101});
        tick();
        chk("flush_f2b", {14'd0, memRead, commandValid, memAddress}, {14'd0, 1'b1, 1'b0, 16'h0102});
        tick();
        chk("flush_cap", {31'd0, commandValid}, 32'd0);
        tick();
        chk("flush_valid", {7'd0, commandValid, commandOut}, {7'd0, 1'b1, 24'h5A6B7C});
        chk("flush_caddr", {16'd0, commandAddress}, 32'h0100);
        commandReady = 1'b1;
        tick();
        commandReady = 1'b0;
        chk("halt_f0", {15'd0, memRead, memAddress}, {15'd0, 1'b1, 16'h0103});

        // Halt command.
        for (int k = 0; k < 4; k++) tick();
        chk("halt_cmd", {7'd0, commandValid, commandOut}, {7'd0, 1'b1, 24'hFFFFFF});
        commandReady = 1'b1;
        tick();
        commandReady = 1'b0;
        chk("halted", {29'd0, halted, commandValid, memRead}, 32'd4);
        redirectAddress = 16'h0200;
        for (int k = 0; k < 20; k++) begin
            redirect = (k % 2 == 1);
            tick();
            chk("halt_hold", {29'd0, halted, commandValid, memRead}, 32'd4);
        end
        redirect = 1'b0;
        chk("addr39_unread", {31'd0, saw39}, 32'd0);

        // Reset out of HALT, asynchronously mid-cycle.
        #2 resetN = 1'b0;
        #1 chk_reset_outputs("reset_halt");
        tick();
        tick();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_idle", {31'd0, memRead}, 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_f0", {15'd0, memRead, memAddress}, {15'd0, 1'b1, 16'h0000});
        for (int k = 0; k < 4; k++) tick();
        chk("restart_valid", {7'd0, commandValid, commandOut}, {7'd0, 1'b1, 24'h110204});

        // Reset pulsed while a command sits in VALID.
        #2 resetN = 1'b0;
        #1 chk_reset_outputs("reset_valid");
        tick();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_after_valid_reset", {30'd0, memRead, commandValid}, 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_f0", {14'd0, memRead, commandValid, memAddress}, {14'd0, 1'b1, 1'b0, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
